// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, constants and stage records for the FP adder packer.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int INT_W   = 37;
  localparam int GUARD_W = 4;
  // hidden bit + stored mantissa + guard bits
  localparam int SIG_W   = MAN_W + 1 + GUARD_W;
  // internal exponent is wide enough that exp+1+1 never wraps
  localparam int IEXP_W  = 10;

  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam logic [MAN_W-1:0] QNAN_MAN = 23'h400000;

  // unpacked adder result as it arrives on NR
  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] m;
  } fp_int_t;

  // stage 1 -> stage 2: normalised significand with guard bits
  typedef struct packed {
    logic              s;
    logic              special;
    logic [IEXP_W-1:0] e;
    logic [SIG_W-1:0]  m;
  } norm_t;

  // stage 2 -> stage 3: rounded 24-bit significand
  typedef struct packed {
    logic              s;
    logic              special;
    logic              nan;
    logic [IEXP_W-1:0] e;
    logic [MAN_W:0]    m;
  } rnd_t;

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter over the 28-bit significand.
// An all-zero input reports 28.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0] din,
  output logic [4:0]       lz
);

  // scan from LSB upward so the highest set bit is the last one to win
  always_comb begin
    lz = 5'd28;
    for (int i = 0; i < SIG_W; i++) begin
      lz = din[i] ? 5'(SIG_W - 1 - i) : lz;
    end
  end

endmodule

// File: rtl/fp_packer.sv
// fp_packer: normalise, round-to-nearest-even and pack an IEEE-754 single at
// the tail of the FP adder. Three register stages share one global stall, so
// the output register is always present.
// Build macro FP_PACK_FLAGS_EN adds FLAGS = {overflow, underflow, inexact}.
module fp_packer
  import fp_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [INT_W-1:0] NR,
  input  logic             COUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      RESULT
`ifdef FP_PACK_FLAGS_EN
  ,
  output logic [2:0]       FLAGS
`endif
);

  fp_int_t           in_s;
  logic              special_in_s;
  logic              adv_s;
  logic [4:0]        lz_s;
  logic [IEXP_W-1:0] e_eff_s;
  logic [IEXP_W-1:0] shift_s;
  logic              up_s;
  logic [MAN_W+1:0]  sum_s;
  norm_t             norm_s, s1_d, s1_q;
  rnd_t              rnd_s, s2_d, s2_q;
  logic [31:0]       pack_s, result_d, result_q;
  logic              s1_valid_d, s1_valid_q;
  logic              s2_valid_d, s2_valid_q;
  logic              out_valid_d, out_valid_q;

  assign in_s         = fp_int_t'(NR);
  assign special_in_s = (in_s.e == EXP_MAX);
  // the whole pipe moves when the output slot is empty or being drained
  assign adv_s        = ~out_valid_q | OUT_READY;
  assign IN_READY     = adv_s;
  assign OUT_VALID    = out_valid_q;
  assign RESULT       = result_q;

  fp_lzc u_lzc (
    .din (in_s.m),
    .lz  (lz_s)
  );

  // stage 1: absorb the carry-out or left-normalise without going below exp 1
  always_comb begin
    e_eff_s  = (in_s.e == 8'h00) ? 10'd1 : {2'b00, in_s.e};
    shift_s  = ({5'd0, lz_s} < (e_eff_s - 10'd1)) ? {5'd0, lz_s} : (e_eff_s - 10'd1);
    norm_s.s = in_s.s;
    norm_s.special = special_in_s;
    if (special_in_s) begin
      norm_s.e = {2'b00, in_s.e};
      norm_s.m = in_s.m;
    end else if (COUT) begin
      norm_s.e = e_eff_s + 10'd1;
      norm_s.m = {1'b1, in_s.m[27:2], in_s.m[1] | in_s.m[0]};
    end else begin
      norm_s.e = e_eff_s - shift_s;
      norm_s.m = in_s.m << shift_s;
    end
  end

  // stage 2: round to nearest even on G/R/sticky, renormalise on mantissa carry
  always_comb begin
    up_s  = s1_q.m[3] & (s1_q.m[2] | (|s1_q.m[1:0]) | s1_q.m[4]);
    sum_s = {1'b0, s1_q.m[27:4]} + {24'd0, up_s};
    rnd_s.s       = s1_q.s;
    rnd_s.special = s1_q.special;
    rnd_s.nan     = (s1_q.m[26:4] != 23'd0);
    if (sum_s[24]) begin
      rnd_s.e = s1_q.e + 10'd1;
      rnd_s.m = sum_s[24:1];
    end else begin
      rnd_s.e = s1_q.e;
      rnd_s.m = sum_s[23:0];
    end
  end

  // stage 3: choose special / overflow / zero / normal / denormal encoding
  always_comb begin
    if (s2_q.special) begin
      pack_s = {s2_q.s, EXP_MAX, s2_q.nan ? QNAN_MAN : 23'h0};
    end else if (s2_q.e >= 10'd255) begin
      pack_s = {s2_q.s, EXP_MAX, 23'h0};
    end else if (s2_q.m == 24'd0) begin
      pack_s = {s2_q.s, 31'h0};
    end else if (s2_q.m[23]) begin
      pack_s = {s2_q.s, s2_q.e[7:0], s2_q.m[22:0]};
    end else begin
      pack_s = {s2_q.s, 8'h00, s2_q.m[22:0]};
    end
  end

  // next state of the data pipe: everything holds while stalled
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    out_valid_d = out_valid_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    result_d    = result_q;
    if (adv_s) begin
      s1_valid_d  = IN_VALID;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
      s1_d        = norm_s;
      s2_d        = rnd_s;
      result_d    = pack_s;
    end else begin
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
    end
  end

  // data pipe registers; reset drops anything in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      result_q    <= 32'h0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      result_q    <= result_d;
    end
  end

`ifdef FP_PACK_FLAGS_EN
  logic       inexact_s;
  logic       s2_inexact_d, s2_inexact_q;
  logic [2:0] flags_s, flags_d, flags_q;

  assign inexact_s = ~s1_q.special & (|s1_q.m[3:0]);
  assign FLAGS     = flags_q;

  // per-result flags {overflow, underflow, inexact}; nothing accumulates
  always_comb begin
    if (s2_q.special) begin
      flags_s = 3'b000;
    end else if (s2_q.e >= 10'd255) begin
      flags_s = 3'b101;
    end else begin
      flags_s = {1'b0, ~s2_q.m[23] & s2_inexact_q, s2_inexact_q};
    end
  end

  // flag pipe follows the same stall as the data
  always_comb begin
    s2_inexact_d = s2_inexact_q;
    flags_d      = flags_q;
    if (adv_s) begin
      s2_inexact_d = inexact_s;
      flags_d      = flags_s;
    end else begin
      s2_inexact_d = s2_inexact_q;
      flags_d      = flags_q;
    end
  end

  // flag pipe registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_inexact_q <= 1'b0;
      flags_q      <= 3'b000;
    end else begin
      s2_inexact_q <= s2_inexact_d;
      flags_q      <= flags_d;
    end
  end
`endif

endmodule

// File: tb/tb_fp_packer.sv
// tb_fp_packer: directed + randomized bench for fp_packer against an
// arithmetic reference model. Honors FP_PACK_FLAGS_EN when defined.
module tb_fp_packer;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [36:0] NR;
  logic        COUT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] RESULT;
  logic [34:0] obs;

`ifdef FP_PACK_FLAGS_EN
  logic [2:0] FLAGS;
  assign obs = {FLAGS, RESULT};
  localparam logic [34:0] CMP_MASK = {35{1'b1}};
`else
  assign obs = {3'b000, RESULT};
  localparam logic [34:0] CMP_MASK = {3'b000, 32'hFFFF_FFFF};
`endif

  fp_packer dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .NR        (NR),
    .COUT      (COUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT)
`ifdef FP_PACK_FLAGS_EN
    ,
    .FLAGS     (FLAGS)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_acc   = 0;
  int          n_out   = 0;
  logic        rand_rdy = 1'b0;
  logic [34:0] exp_q[$];

  typedef struct packed {
    logic        c;
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [34:0] x;
  } dvec_t;
  dvec_t dir_tab [16];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // random output back-pressure when enabled
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rand_rdy) OUT_READY = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check_eq(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: value {c,m} * 2^(E-27), normalise, RNE on 4 guard bits, encode
  function automatic logic [34:0] ref_pack(input logic s, input logic [7:0] e,
                                           input logic [27:0] m, input logic c);
    longint x, q;
    int     ex, rem;
    logic   inx, ovf, unf, up;
    logic [31:0] r;
    ovf = 1'b0; unf = 1'b0;
    if (e == 8'hFF) begin
      r = {s, 8'hFF, (m[26:4] == 23'd0) ? 23'd0 : 23'h400000};
      return {3'b000, r};
    end
    ex = (e == 8'd0) ? 1 : int'(e);
    x  = longint'({c, m});
    if (c) begin
      x  = (x >> 1) | (x & 64'd1);
      ex = ex + 1;
    end else begin
      while (x != 0 && x < 64'h8000000 && ex > 1) begin
        x  = x * 2;
        ex = ex - 1;
      end
    end
    q   = x / 16;
    rem = int'(x % 16);
    inx = (rem != 0);
    up  = (rem >= 8) && ((rem > 8) || (q % 2 == 1));
    if (up) q = q + 1;
    if (q >= 64'h1000000) begin
      q  = q / 2;
      ex = ex + 1;
    end
    if (ex >= 255) begin
      r = {s, 8'hFF, 23'd0};
      ovf = 1'b1;
      inx = 1'b1;
    end else if (q == 0) begin
      r = {s, 31'd0};
      unf = inx;
    end else if (q >= 64'h800000) begin
      r = {s, 8'(ex), 23'(q)};
    end else begin
      r = {s, 8'd0, 23'(q)};
      unf = inx;
    end
    return {ovf, unf, inx, r};
  endfunction

  // scoreboard: record accepted inputs, compare delivered outputs in order
  always @(negedge CLK) begin
    if (RST_N) begin
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", {34'd0, OUT_VALID}, 35'd0);
        end else begin
          check_eq("result", obs, exp_q.pop_front());
          n_out++;
        end
      end
      if (IN_VALID && IN_READY) begin
        exp_q.push_back(ref_pack(NR[36], NR[35:28], NR[27:0], COUT) & CMP_MASK);
        n_acc++;
      end
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m, input logic c);
    IN_VALID = 1'b1;
    NR       = {s, e, m};
    COUT     = c;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      if (IN_READY) begin
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        return;
      end
    end
    check_eq("send_timeout", {34'd0, IN_READY}, 35'd1);
    IN_VALID = 1'b0;
  endtask

  task automatic rand_vec(output logic s, output logic [7:0] e, output logic [27:0] m,
                          output logic c);
    logic [7:0] etab [8];
    etab = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'hFD, 8'hFE, 8'hFF};
    s = 1'($urandom());
    e = ($urandom_range(0, 1) == 0) ? etab[$urandom_range(0, 7)] : 8'($urandom());
    m = 28'($urandom());
    m = m >> $urandom_range(0, 28);
    c = ($urandom_range(0, 5) == 0);
  endtask

  task automatic run_one(input int idx);
    dvec_t v;
    v = dir_tab[idx];
    send(v.s, v.e, v.m, v.c);
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      if (OUT_VALID) break;
    end
    check_eq($sformatf("dir%0d", idx), obs, v.x & CMP_MASK);
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !OUT_VALID) break;
    end
    check_eq("drain_empty", 35'(exp_q.size()), 35'd0);
    check_eq("in_out_count", 35'(n_out), 35'(n_acc));
  endtask

  initial begin
    int          lat;
    int          acc;
    logic        s, c;
    logic [7:0]  e;
    logic [27:0] m;

    dir_tab[0]  = {1'b0, 1'b0, 8'h7F, 28'h8000000, 3'b000, 32'h3F800000};
    dir_tab[1]  = {1'b1, 1'b0, 8'h7F, 28'h0000000, 3'b000, 32'h40000000};
    dir_tab[2]  = {1'b0, 1'b0, 8'h7F, 28'h0800000, 3'b000, 32'h3D800000};
    dir_tab[3]  = {1'b0, 1'b0, 8'h7F, 28'h8000008, 3'b001, 32'h3F800000};
    dir_tab[4]  = {1'b0, 1'b0, 8'h7F, 28'h8000018, 3'b001, 32'h3F800002};
    dir_tab[5]  = {1'b0, 1'b0, 8'h7F, 28'hFFFFFF8, 3'b001, 32'h40000000};
    dir_tab[6]  = {1'b1, 1'b0, 8'hFE, 28'h8000000, 3'b101, 32'h7F800000};
    dir_tab[7]  = {1'b0, 1'b0, 8'hFF, 28'h0000010, 3'b000, 32'h7FC00000};
    dir_tab[8]  = {1'b0, 1'b1, 8'hFF, 28'h8000000, 3'b000, 32'hFF800000};
    dir_tab[9]  = {1'b0, 1'b0, 8'h01, 28'h0000010, 3'b000, 32'h00000001};
    dir_tab[10] = {1'b0, 1'b0, 8'h55, 28'h0000000, 3'b000, 32'h00000000};
    dir_tab[11] = {1'b0, 1'b1, 8'h55, 28'h0000000, 3'b000, 32'h80000000};
    dir_tab[12] = {1'b0, 1'b0, 8'h00, 28'h8000000, 3'b000, 32'h00800000};
    dir_tab[13] = {1'b0, 1'b0, 8'h01, 28'h0000018, 3'b011, 32'h00000002};
    dir_tab[14] = {1'b0, 1'b1, 8'h02, 28'h4000000, 3'b000, 32'h80800000};
    dir_tab[15] = {1'b0, 1'b0, 8'h02, 28'h2000000, 3'b000, 32'h00400000};

    RST_N = 1'b0; IN_VALID = 1'b0; NR = 37'd0; COUT = 1'b0; OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_out_valid", {34'd0, OUT_VALID}, 35'd0);
    check_eq("rst_result", obs, 35'd0);
    check_eq("rst_in_ready", {34'd0, IN_READY}, 35'd1);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // latency from accept to OUT_VALID on an empty pipe
    send(1'b0, 8'h7F, 28'h8000000, 1'b0);
    lat = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge CLK);
      lat++;
      if (OUT_VALID) break;
    end
    check_eq("latency", 35'(lat), 35'd3);
    drain();

    for (int i = 0; i < 16; i++) run_one(i);
    drain();

    // back-pressure: output stalled for five cycles with input always offered
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      rand_vec(s, e, m, c);
      NR = {s, e, m};
      COUT = c;
      @(negedge CLK);
      if (IN_READY) acc++;
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0;
    check_eq("bp_accepts", 35'(acc), 35'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_eq("bp_in_ready", {34'd0, IN_READY}, 35'd0);
      check_eq("bp_hold", obs, (exp_q.size() > 0) ? exp_q[0] : 35'h7_FFFF_FFFF);
    end
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    drain();

    // randomized traffic with random gaps and random back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      rand_vec(s, e, m, c);
      send(s, e, m, c);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK);
        #1;
      end
    end
    rand_rdy  = 1'b0;
    OUT_READY = 1'b1;
    drain();

    // reset in the middle of a stalled stream
    OUT_READY = 1'b0;
    rand_vec(s, e, m, c);
    send(s, e, m, c);
    rand_vec(s, e, m, c);
    send(s, e, m, c);
    for (int t = 0; t < 10; t++) begin
      @(negedge CLK);
      if (OUT_VALID) break;
    end
    check_eq("pre_rst_valid", {34'd0, OUT_VALID}, 35'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("mid_rst_valid", {34'd0, OUT_VALID}, 35'd0);
    check_eq("mid_rst_result", obs, 35'd0);
    exp_q.delete();
    n_acc = 0;
    n_out = 0;
    repeat (2) @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    RST_N = 1'b1;
    run_one(5);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
